// File: rtl/jelly_texture_blk_reader.sv
// Block texture reader: turns one (x, y) block request into ROWS row bursts on the
// memory AR channel and passes the returned beats through, marking the end of each block.
module jelly_texture_blk_reader #(
    parameter int ADDR_X_WIDTH    = 12,
    parameter int ADDR_Y_WIDTH    = 12,
    parameter int BLK_X_SIZE      = 2,
    parameter int BLK_Y_SIZE      = 2,
    parameter int M_DATA_SIZE     = 1,
    parameter int PIXEL_BYTES     = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int STRIDE_WIDTH    = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_WIDTH      = (8*PIXEL_BYTES) << M_DATA_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   param_addr,
    input  logic [STRIDE_WIDTH-1:0] param_stride,
    input  logic [ADDR_X_WIDTH-1:0] s_araddrx,
    input  logic [ADDR_Y_WIDTH-1:0] s_araddry,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic                    err
);

    localparam int BEATS = 1 << (BLK_X_SIZE - M_DATA_SIZE);
    localparam int ROWS  = 1 << BLK_Y_SIZE;
    localparam int BW    = (BLK_X_SIZE - M_DATA_SIZE) > 0 ? (BLK_X_SIZE - M_DATA_SIZE) : 1;
    localparam int RW    = BLK_Y_SIZE > 0 ? BLK_Y_SIZE : 1;
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [ADDR_X_WIDTH-1:0] X_MASK = ADDR_X_WIDTH'((1 << BLK_X_SIZE) - 1);
    localparam logic [ADDR_Y_WIDTH-1:0] Y_MASK = ADDR_Y_WIDTH'((1 << BLK_Y_SIZE) - 1);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_X_WIDTH-1:0] x_q, x_d;
    logic [ADDR_Y_WIDTH-1:0] y_q, y_d;
    logic [ADDR_WIDTH-1:0]   row_addr_q, row_addr_d;
    logic [RW-1:0]           arow_q, arow_d;
    logic [OW-1:0]           out_q, out_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [RW-1:0]           drow_q, drow_d;
    logic                    err_q, err_d;

    logic ar_acc, blk_done, beat_acc, beat_is_last;

    // reset is folded in so the request port reads not-ready while held in reset
    assign s_arready = reset && (state_q == IDLE) && (out_q < OW'(MAX_OUTSTANDING));
    assign ar_acc    = s_arvalid && s_arready;

    assign m_arvalid = (state_q == ISSUE);
    assign m_araddr  = row_addr_q;
    assign m_arlen   = (state_q == ISSUE) ? 8'(BEATS - 1) : 8'd0;

    assign s_rdata   = m_rdata;
    assign s_rvalid  = m_rvalid;
    assign m_rready  = s_rready;
    assign s_rlast   = m_rlast && (drow_q == ROW_LAST);
    assign err       = err_q;

    assign blk_done     = s_rvalid && s_rready && s_rlast;
    assign beat_acc     = m_rvalid && m_rready;
    assign beat_is_last = (beat_q == BEAT_LAST);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        row_addr_d = row_addr_q;
        arow_d     = arow_q;
        case (state_q)
            IDLE: begin
                if (ar_acc) begin
                    x_d     = s_araddrx & ~X_MASK;
                    y_d     = s_araddry & ~Y_MASK;
                    state_d = CALC;
                end
            end
            CALC: begin
                row_addr_d = param_addr
                           + ADDR_WIDTH'(y_q) * ADDR_WIDTH'(param_stride)
                           + ADDR_WIDTH'(x_q) * ADDR_WIDTH'(PIXEL_BYTES);
                arow_d     = '0;
                state_d    = ISSUE;
            end
            ISSUE: begin
                if (m_arready) begin
                    if (arow_q == ROW_LAST) begin
                        arow_d  = '0;
                        state_d = IDLE;
                    end else begin
                        row_addr_d = row_addr_q + ADDR_WIDTH'(param_stride);
                        arow_d     = arow_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        case ({ar_acc, blk_done})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    // data-side position follows the beat count; m_rlast only feeds the error check
    always_comb begin
        beat_d = beat_q;
        drow_d = drow_q;
        err_d  = err_q;
        if (beat_acc) begin
            if (m_rlast != beat_is_last) err_d = 1'b1;
            if (beat_is_last) begin
                beat_d = '0;
                drow_d = (drow_q == ROW_LAST) ? '0 : drow_q + RW'(1);
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            row_addr_q <= '0;
            arow_q     <= '0;
            out_q      <= '0;
            beat_q     <= '0;
            drow_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_addr_q <= row_addr_d;
            arow_q     <= arow_d;
            out_q      <= out_d;
            beat_q     <= beat_d;
            drow_q     <= drow_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_jelly_texture_blk_reader.sv
// Bench for jelly_texture_blk_reader: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_jelly_texture_blk_reader;

    localparam int BEATS = 2;
    localparam int ROWS  = 4;
    localparam int MAXO  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] param_addr = 32'h1000_0000;
    logic [15:0] param_stride = 16'd2560;
    logic [11:0] s_araddrx = '0, s_araddry = '0;
    logic        s_arvalid = 1'b0, s_arready;
    logic [63:0] s_rdata;
    logic        s_rlast, s_rvalid;
    logic        s_rready = 1'b0;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [63:0] m_rdata = '0;
    logic        m_rlast = 1'b0, m_rvalid = 1'b0;
    logic        m_rready, err;

    jelly_texture_blk_reader dut (
        .clk(clk), .reset(reset), .param_addr(param_addr), .param_stride(param_stride),
        .s_araddrx(s_araddrx), .s_araddry(s_araddry), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready), .err(err)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: pending row addresses per block, outstanding blocks, running beat count.
    logic [31:0] exp_q[$];
    bit          busy = 0;
    int          since_acc = 0;
    int          out_cnt = 0;
    int          data_n = 0;
    bit          err_m = 0;
    logic [31:0] ar_log[$];
    int          ar_cyc[$];
    int          acc_cyc[$];
    int          rlast_log[$];

    always @(negedge clk) begin
        bit exp_rdy, exp_av;
        logic [31:0] base;
        if (reset) begin
            exp_rdy = !busy && (out_cnt < MAXO);
            exp_av  = busy && (since_acc >= 1);
            chk("s_arready", s_arready, exp_rdy);
            chk("m_arvalid", m_arvalid, exp_av);
            if (exp_av) begin
                chk("m_araddr", m_araddr, exp_q[0]);
                chk("m_arlen", m_arlen, BEATS - 1);
            end
            chk("s_rvalid", s_rvalid, m_rvalid);
            chk("m_rready", m_rready, s_rready);
            if (m_rvalid) begin
                chk("s_rdata", s_rdata, m_rdata);
                chk("s_rlast", s_rlast, m_rlast && (((data_n / BEATS) % ROWS) == ROWS - 1));
            end
            chk("err", err, err_m);

            if (busy) since_acc++;
            if (exp_av && m_arready) begin
                ar_log.push_back(m_araddr);
                ar_cyc.push_back(cyc);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) busy = 0;
            end
            if (m_rvalid && s_rready) begin
                if (m_rlast != ((data_n % BEATS) == BEATS - 1)) err_m = 1;
                if (m_rlast && ((data_n / BEATS) % ROWS) == ROWS - 1) begin
                    out_cnt--;
                    rlast_log.push_back(data_n);
                end
                data_n++;
            end
            if (s_arvalid && exp_rdy) begin
                base = param_addr + 32'({s_araddry[11:2], 2'b00}) * 32'(param_stride)
                     + 32'({s_araddrx[11:2], 2'b00}) * 32'd4;
                for (int r = 0; r < ROWS; r++) exp_q.push_back(base + 32'(r) * 32'(param_stride));
                busy = 1;
                since_acc = 0;
                out_cnt++;
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic idle_inputs();
        s_arvalid = 0; m_arready = 0; s_rready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = '0;
    endtask

    task automatic clear_logs();
        ar_log.delete(); ar_cyc.delete(); acc_cyc.delete(); rlast_log.delete();
    endtask

    task automatic do_reset();
        reset = 0;
        idle_inputs();
        exp_q.delete(); busy = 0; since_acc = 0; out_cnt = 0; data_n = 0; err_m = 0;
        clear_logs();
        #1;
        chk("rst_s_arready", s_arready, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_m_arlen", m_arlen, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        #1 chk("post_rst_s_arready", s_arready, 1);
    endtask

    task automatic send_beats(input int n, input int rlast_mod);
        for (int i = 0; i < n; i++) begin
            m_rvalid = 1; s_rready = 1; m_rdata = {$urandom, $urandom};
            m_rlast = ((i % rlast_mod) == rlast_mod - 1);
            @(posedge clk); #1;
        end
        m_rvalid = 0; m_rlast = 0;
    endtask

    task automatic check_block_addrs(input string tag);
        logic [31:0] lit [4];
        lit[0] = 32'h1000_2820; lit[1] = 32'h1000_3220; lit[2] = 32'h1000_3C20; lit[3] = 32'h1000_4620;
        chk({tag, "_ar_count"}, ar_log.size(), 4);
        for (int i = 0; i < 4 && i < ar_log.size(); i++) chk({tag, "_ar_addr"}, ar_log[i], lit[i]);
    endtask

    initial begin
        #2;
        param_addr = 32'h1000_0000; param_stride = 16'd2560;
        do_reset();

        // block (8,4): four rows, first AR two cycles after accept
        s_arvalid = 1; s_araddrx = 12'd8; s_araddry = 12'd4; m_arready = 1;
        @(posedge clk); #1 s_arvalid = 0;
        repeat (8) @(posedge clk); #1;
        check_block_addrs("blk8_4");
        chk("first_ar_latency", (ar_cyc.size() > 0 && acc_cyc.size() > 0) ? ar_cyc[0] - acc_cyc[0] : -1, 2);

        // 8 beats, m_rlast every second beat: single s_rlast on the 8th
        send_beats(8, 2);
        chk("rlast_count", rlast_log.size(), 1);
        chk("rlast_beat", rlast_log.size() > 0 ? rlast_log[0] : -1, 7);
        chk("err_clean", err, 0);

        // five requests, no data: four accepted until a block completes
        clear_logs();
        s_arvalid = 1; s_araddrx = 12'd0; s_araddry = 12'd0; m_arready = 1;
        repeat (40) @(posedge clk); #1;
        chk("accepts_at_limit", acc_cyc.size(), 4);
        chk("s_arready_full", s_arready, 0);
        send_beats(8, 2);
        chk("s_arready_after_done", s_arready, 1);
        @(posedge clk); #1 s_arvalid = 0;
        chk("accepts_after_done", acc_cyc.size(), 5);
        do_reset();

        // unaligned (11,6) maps to the (8,4) block; AR stalled for 10 cycles
        s_arvalid = 1; s_araddrx = 12'd11; s_araddry = 12'd6; m_arready = 0;
        @(posedge clk); #1 s_arvalid = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_arvalid", m_arvalid, 1);
            chk("stall_araddr", m_araddr, 32'h1000_2820);
            @(posedge clk); #1;
        end
        m_arready = 1;
        repeat (6) @(posedge clk); #1;
        check_block_addrs("blk11_6");
        do_reset();

        // m_rlast on the first beat sets a sticky error
        send_beats(1, 1);
        chk("err_set", err, 1);
        repeat (5) @(posedge clk); #1;
        chk("err_sticky", err, 1);
        // reset during ISSUE drops m_arvalid and err at once
        s_arvalid = 1; s_araddrx = 12'd0; s_araddry = 12'd0; m_arready = 0;
        @(posedge clk); #1 s_arvalid = 0;
        @(posedge clk); #1;
        chk("issue_before_rst", m_arvalid, 1);
        reset = 0;
        #1;
        chk("rst_mid_arvalid", m_arvalid, 0);
        chk("rst_mid_err", err, 0);
        param_addr = $urandom; param_stride = 16'($urandom);
        do_reset();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            s_arvalid = ($urandom % 3) == 0;
            s_araddrx = 12'($urandom); s_araddry = 12'($urandom);
            m_arready = ($urandom % 4) != 0;
            s_rready  = ($urandom % 4) != 0;
            m_rvalid  = (out_cnt > 0) && (($urandom % 2) == 0);
            m_rlast   = m_rvalid && ((data_n % BEATS) == BEATS - 1);
            m_rdata   = m_rvalid ? {$urandom, $urandom} : '0;
            @(posedge clk); #1;
        end
        idle_inputs();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
